fcvt_f_int_pipe: RTL

//  Pipelined integer-to-float converter (FCVT.S.W / FCVT.S.WU / FCVT.S.L / FCVT.S.LU class).

---
 rtl/fcvt_f_int_pipe.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/fcvt_f_int_pipe.sv
// Pipelined integer-to-float converter: sign/magnitude, normalise, round, then a registered output stage.
// Each stage loads when it is empty or when the stage after it is loading.
module fcvt_f_int_pipe #(
  parameter int F_WIDTH = 32,
  parameter int F_EXP   = 8,
  parameter int F_FLAC  = 23,
  parameter int I_WIDTH = 32
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [I_WIDTH-1:0] in1,
  input  logic               is_signed,
  input  logic [2:0]         rm,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [F_WIDTH-1:0] out1,
  output logic               inexact,
  output logic               illegal_rm
);
  localparam int LZW = $clog2(I_WIDTH);
  localparam int IW1 = I_WIDTH - 1;
  localparam int EW  = I_WIDTH + F_FLAC + 1;
  localparam logic [F_EXP-1:0] BIAS = {1'b0, {(F_EXP-1){1'b1}}};
  localparam logic [F_EXP-1:0] TOP  = F_EXP'(I_WIDTH - 1);

  // vld_q[0..2] = stages 1..3, vld_q[3] = output register
  logic [3:0] vld_q;
  logic       ld0, ld1, ld2, ld3;

  logic               s1_sign_q, s1_zero_q;
  logic [I_WIDTH-1:0] s1_mag_q;
  logic [2:0]         s1_rm_q;

  logic               s2_sign_q, s2_zero_q;
  logic [2:0]         s2_rm_q;
  logic [LZW-1:0]     s2_lz_q;
  logic [IW1-1:0]     s2_frac_q;

  logic               s3_sign_q, s3_zero_q, s3_nx_q, s3_ill_q;
  logic [F_FLAC:0]    s3_mant_q;
  logic [F_EXP-1:0]   s3_exp_q;

  logic [F_WIDTH-1:0] out1_q;
  logic               nx_q, ill_q;

  always_comb begin
    ld3 = ~vld_q[3] | out_ready;
    ld2 = ~vld_q[2] | ld3;
    ld1 = ~vld_q[1] | ld2;
    ld0 = ~vld_q[0] | ld1;
  end

  // stage 1: two's-complement magnitude; the most negative value maps to 2**(I_WIDTH-1)
  logic               s1_sign_d;
  logic [I_WIDTH-1:0] s1_mag_d;
  always_comb begin
    s1_sign_d = is_signed & in1[I_WIDTH-1];
    s1_mag_d  = s1_sign_d ? (~in1 + 1'b1) : in1;
  end

  // stage 2: leading-zero count, then drop the hidden bit after shifting
  logic [LZW-1:0] s2_lz_d;
  logic [IW1-1:0] s2_frac_d;
  always_comb begin
    s2_lz_d = '0;
    for (int i = 0; i < I_WIDTH; i++)
      if (s1_mag_q[i]) s2_lz_d = LZW'(I_WIDTH - 1 - i);
    s2_frac_d = IW1'(s1_mag_q << s2_lz_d);
  end

  // stage 3: zero padding below the fraction makes narrow integer formats exact (G=S=0)
  logic [EW-1:0]     ext;
  logic [F_FLAC-1:0] kept;
  logic              g, s, inc, ill;
  logic [2:0]        rme;
  logic [F_FLAC:0]   s3_mant_d;
  logic [F_EXP-1:0]  s3_exp_d;
  always_comb begin
    ext  = {s2_frac_q, {(F_FLAC+2){1'b0}}};
    kept = ext[EW-1 -: F_FLAC];
    g    = ext[EW-1-F_FLAC];
    s    = |ext[EW-2-F_FLAC:0];
    ill  = s2_rm_q > 3'd4;
    rme  = ill ? 3'd0 : s2_rm_q;
    case (rme)
      3'd0:    inc = g & (s | kept[0]);
      3'd1:    inc = 1'b0;
      3'd2:    inc = s2_sign_q & (g | s);
      3'd3:    inc = ~s2_sign_q & (g | s);
      default: inc = g;
    endcase
    s3_mant_d = {1'b0, kept} + {{F_FLAC{1'b0}}, inc};
    s3_exp_d  = BIAS + TOP - F_EXP'(s2_lz_q);
  end

  // output: a mantissa carry leaves the fraction at zero and bumps the exponent
  logic [F_WIDTH-1:0] out1_d;
  always_comb begin
    out1_d = s3_zero_q ? '0 :
             {s3_sign_q, s3_exp_q + {{(F_EXP-1){1'b0}}, s3_mant_q[F_FLAC]}, s3_mant_q[F_FLAC-1:0]};
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      vld_q     <= '0;
      s1_sign_q <= 1'b0; s1_zero_q <= 1'b0; s1_mag_q <= '0; s1_rm_q <= '0;
      s2_sign_q <= 1'b0; s2_zero_q <= 1'b0; s2_rm_q <= '0; s2_lz_q <= '0; s2_frac_q <= '0;
      s3_sign_q <= 1'b0; s3_zero_q <= 1'b0; s3_nx_q <= 1'b0; s3_ill_q <= 1'b0;
      s3_mant_q <= '0; s3_exp_q <= '0;
      out1_q    <= '0; nx_q <= 1'b0; ill_q <= 1'b0;
    end else begin
      if (ld0) begin
        vld_q[0] <= in_valid;
        if (in_valid) begin
          s1_sign_q <= s1_sign_d;
          s1_zero_q <= (in1 == '0);
          s1_mag_q  <= s1_mag_d;
          s1_rm_q   <= rm;
        end
      end
      if (ld1) begin
        vld_q[1] <= vld_q[0];
        if (vld_q[0]) begin
          s2_sign_q <= s1_sign_q;
          s2_zero_q <= s1_zero_q;
          s2_rm_q   <= s1_rm_q;
          s2_lz_q   <= s2_lz_d;
          s2_frac_q <= s2_frac_d;
        end
      end
      if (ld2) begin
        vld_q[2] <= vld_q[1];
        if (vld_q[1]) begin
          s3_sign_q <= s2_sign_q;
          s3_zero_q <= s2_zero_q;
          s3_nx_q   <= g | s;
          s3_ill_q  <= ill;
          s3_mant_q <= s3_mant_d;
          s3_exp_q  <= s3_exp_d;
        end
      end
      if (ld3) begin
        vld_q[3] <= vld_q[2];
        if (vld_q[2]) begin
          out1_q <= out1_d;
          nx_q   <= s3_nx_q & ~s3_zero_q;
          ill_q  <= s3_ill_q;
        end
      end
    end
  end

  assign in_ready   = ld0;
  assign out_valid  = vld_q[3];
  assign out1       = out1_q;
  assign inexact    = nx_q;
  assign illegal_rm = ill_q;
endmodule
